demux12_32_buf: RTL

- 1:2 demultiplexer with buffering; the receive-side counterpart of the team's 2:1 32-bit mux.
- Takes one 32-bit input word stream and routes each word by sel to output channel 1 (sel=0) or channel 2 (sel=1).
- Each channel has its own small FIFO and a valid/ready handshake, so a stalled consumer on one channel does not block traffic bound for the other until that channel's FIFO is full.
- Sits between the shared datapath bus and two downstream consumers.

---
 rtl/demux12_32_buf_if.sv | 32 +++
 rtl/demux12_32_buf.sv | 124 ++++++++++++
 2 files changed

// File: rtl/demux12_32_buf_if.sv
// Bus bundle for the 1:2 buffered demultiplexer: one input word stream with
// its destination select, and two independent valid/ready output channels
// each carrying a delivered-word counter.
interface demux12_32_buf_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             sel;
    logic             in_ready;
    logic [WIDTH-1:0] out1;
    logic             valid1;
    logic             ready1;
    logic [WIDTH-1:0] out2;
    logic             valid2;
    logic             ready2;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;

    // Producer/consumer side: drives the input word and both consumer readies
    modport master (
        output in, in_valid, sel, ready1, ready2,
        input  in_ready, out1, valid1, out2, valid2, cnt1, cnt2
    );

    // Demultiplexer side
    modport slave (
        input  in, in_valid, sel, ready1, ready2,
        output in_ready, out1, valid1, out2, valid2, cnt1, cnt2
    );
endinterface

// File: rtl/demux12_32_buf.sv
// 1:2 buffered demultiplexer. Each input word is steered by sel into one of
// two small FIFOs; each FIFO drains through its own valid/ready handshake, so
// a stalled consumer only back-pressures words destined for its own channel.
// The head word of each FIFO is held in an output register, so outN never
// follows the input combinationally and keeps its last value once drained.
module demux12_32_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    demux12_32_buf_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ZERO  = {(PTR_W + 1){1'b0}};
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] DCNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] DCNT_ONE  = CNT_W'(1'b1);
    localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

    logic [1:0]       w_full;
    logic [1:0]       w_valid;
    logic [1:0]       w_ready_in;
    logic [WIDTH-1:0] w_out [2];
    logic [CNT_W-1:0] w_cnt [2];

    assign w_ready_in[0] = bus.ready1;
    assign w_ready_in[1] = bus.ready2;

    assign bus.out1   = w_out[0];
    assign bus.out2   = w_out[1];
    assign bus.valid1 = w_valid[0];
    assign bus.valid2 = w_valid[1];
    assign bus.cnt1   = w_cnt[0];
    assign bus.cnt2   = w_cnt[1];

    // Back-pressure reflects only the fullness of the channel sel points at
    always_comb begin
        bus.in_ready = 1'b1;
        if (bus.sel == 1'b0) begin
            bus.in_ready = !w_full[0];
        end else begin
            bus.in_ready = !w_full[1];
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0] r_wr_ptr;
        logic [PTR_W-1:0] r_rd_ptr;
        logic [PTR_W:0]   r_count;
        logic [WIDTH-1:0] r_out;
        logic [CNT_W-1:0] r_cnt;

        logic             w_push;
        logic             w_pop;
        logic [PTR_W-1:0] w_rd_inc;
        logic [PTR_W:0]   w_count_next;
        logic [WIDTH-1:0] w_out_next;

        assign w_full[ch]  = (r_count == CNT_FULL);
        assign w_valid[ch] = (r_count != CNT_ZERO);
        assign w_out[ch]   = r_out;
        assign w_cnt[ch]   = r_cnt;

        // Fullness gating here matches in_ready for this channel's select value
        assign w_push   = bus.in_valid && !w_full[ch] && (bus.sel == 1'(ch));
        assign w_pop    = w_valid[ch] && w_ready_in[ch];
        assign w_rd_inc = r_rd_ptr + PTR_ONE;

        // Occupancy after this edge's push and/or pop
        always_comb begin
            w_count_next = r_count;
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + CNT_ONE;
                2'b01:   w_count_next = r_count - CNT_ONE;
                default: w_count_next = r_count;
            endcase
        end

        // Head word after this edge: next stored entry, the incoming word if
        // it lands in an otherwise-empty FIFO, or hold the current value
        always_comb begin
            w_out_next = r_out;
            if (w_pop && (r_count > CNT_ONE)) begin
                w_out_next = r_mem[w_rd_inc];
            end else if (w_push && ((r_count == CNT_ZERO) || (w_pop && (r_count == CNT_ONE)))) begin
                w_out_next = bus.in;
            end else begin
                w_out_next = r_out;
            end
        end

        // FIFO storage, pointers, head register and delivered-word counter
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i] <= WORD_ZERO;
                end
                r_wr_ptr <= PTR_ZERO;
                r_rd_ptr <= PTR_ZERO;
                r_count  <= CNT_ZERO;
                r_out    <= WORD_ZERO;
                r_cnt    <= DCNT_ZERO;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= bus.in;
                    r_wr_ptr        <= r_wr_ptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= w_rd_inc;
                    r_cnt    <= r_cnt + DCNT_ONE;
                end
                r_count <= w_count_next;
                r_out   <= w_out_next;
            end
        end
    end

endmodule
